// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the cache control path.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemReq,
    StFill,
    StRelook,
    StRespond
  } state_t;

  localparam int unsigned TAG_HI      = 15;
  localparam int unsigned TAG_LO      = 8;
  localparam int unsigned IDX_HI      = 7;
  localparam int unsigned IDX_LO      = 5;
  localparam int unsigned OFF_W       = 5;
  localparam int unsigned BLOCK_BYTES = 32;

endpackage

// File: rtl/cache_sat_counter.sv
// Saturating up-counter; clear wins over increment.
module cache_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cache_controller.sv
// Read-only control FSM for a 2-way set-associative cache datapath: lookup, block
// refill from memory, re-lookup, byte return, plus hit/miss performance counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BLOCK_W = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic [7:0]         cpu_rdata,
  output logic [ADDR_W-1:0]  dp_address,
  output logic               dp_writeLM,
  output logic               dp_writeLRUM,
  output logic               dp_writeTag,
  output logic               dp_writeCWay,
  output logic [BLOCK_W-1:0] dp_inblock,
  input  logic               dp_miss,
  input  logic [BLOCK_W-1:0] dp_outblock,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output logic               refill_err
);

  state_t r_state, w_state_next;

  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [7:0]         r_rdata;
  logic [BLOCK_W-1:0] r_inblock;
  logic               r_refill_err;
  logic [OFF_W+2:0]   w_bit_idx;
  logic [7:0]         w_byte;
  logic               w_hit_inc;
  logic               w_miss_inc;

  assign w_bit_idx  = {r_addr[OFF_W-1:0], 3'b000};
  assign w_byte     = dp_outblock[w_bit_idx +: 8];
  assign w_hit_inc  = (r_state == StLookup) && !dp_miss;
  assign w_miss_inc = (r_state == StLookup) && dp_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (cpu_req) w_state_next = StLookup;
      StLookup:  w_state_next = dp_miss ? StMemReq : StRespond;
      StMemReq:  if (mem_ack) w_state_next = StFill;
      StFill:    w_state_next = StRelook;
      StRelook:  w_state_next = StRespond;
      StRespond: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    cpu_ready    = 1'b0;
    mem_req      = 1'b0;
    dp_writeLRUM = 1'b0;
    dp_writeTag  = 1'b0;
    dp_writeCWay = 1'b0;
    dp_writeLM   = 1'b0;
    unique case (r_state)
      StLookup:  dp_writeLRUM = !dp_miss;
      StMemReq:  mem_req = 1'b1;
      StFill: begin
        dp_writeTag  = 1'b1;
        dp_writeCWay = 1'b1;
        dp_writeLM   = 1'b1;
      end
      StRespond: cpu_ready = 1'b1;
      default: ;
    endcase
  end

  // Request-scoped registers; address is only captured on accept so it stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_rdata      <= '0;
      r_inblock    <= '0;
      r_refill_err <= 1'b0;
    end else begin
      case (r_state)
        StIdle: if (cpu_req) r_addr <= cpu_addr;
        StLookup: begin
          if (dp_miss) r_mem_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          else         r_rdata    <= w_byte;
        end
        StMemReq: if (mem_ack) r_inblock <= mem_rdata;
        StRelook: begin
          r_rdata <= w_byte;
          if (dp_miss) r_refill_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dp_address = r_addr;
  assign mem_addr   = r_mem_addr;
  assign cpu_rdata  = r_rdata;
  assign dp_inblock = r_inblock;
  assign refill_err = r_refill_err;

  cache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  cache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (w_miss_inc),
    .count (miss_count)
  );

endmodule
